// File: rtl/imm_gen_pipe_if.sv
// Handshake bundle for imm_gen_pipe: upstream instruction channel and
// downstream decoded-immediate channel.
interface imm_gen_pipe_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       in_type;
    logic [31:0]      in_inst;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_imm;
    logic [TAG_W-1:0] out_tag;
    logic             out_illegal;

    modport master (
        output in_valid, in_type, in_inst, in_tag, out_ready,
        input  in_ready, out_valid, out_imm, out_tag, out_illegal
    );

    modport slave (
        input  in_valid, in_type, in_inst, in_tag, out_ready,
        output in_ready, out_valid, out_imm, out_tag, out_illegal
    );
endinterface

// File: rtl/imm_gen_pipe.sv
// RISC-V immediate decoder with a registered output stage and one skid entry;
// in_ready is a flop so there is no combinational path from out_ready.
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input logic          clk,
    input logic          rst,
    input logic          flush,
    imm_gen_pipe_if.slave bus
);
    typedef enum logic [3:0] {
        IT_LOAD  = 4'd0,
        IT_IMM   = 4'd1,
        IT_STORE = 4'd2,
        IT_REG   = 4'd3,
        IT_LUI   = 4'd4,
        IT_AUIPC = 4'd5,
        IT_BRNCH = 4'd6,
        IT_JALR  = 4'd7,
        IT_JAL   = 4'd8,
        IT_CSR   = 4'd9,
        IT_SHIFT = 4'd10
    } itype_e;

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        logic [TAG_W-1:0] tag;
        logic             ill;
    } entry_t;

    entry_t out_q, out_d;
    entry_t skid_q, skid_d;
    logic   out_valid_q, out_valid_d;
    logic   skid_valid_q, skid_valid_d;
    logic   in_ready_q, in_ready_d;

    entry_t             dec;
    logic signed [31:0] s32;
    logic               in_xfer;
    logic               out_xfer;

    always_comb begin
        s32     = '0;
        dec     = '0;
        dec.tag = bus.in_tag;
        case (itype_e'(bus.in_type))
            IT_LOAD, IT_IMM, IT_JALR: begin
                s32     = 32'($signed(bus.in_inst[31:20]));
                dec.imm = XLEN'(s32);
            end
            IT_STORE: begin
                s32     = 32'($signed({bus.in_inst[31:25], bus.in_inst[11:7]}));
                dec.imm = XLEN'(s32);
            end
            IT_BRNCH: begin
                s32     = 32'($signed({bus.in_inst[31], bus.in_inst[7], bus.in_inst[30:25],
                                       bus.in_inst[11:8], 1'b0}));
                dec.imm = XLEN'(s32);
            end
            IT_LUI, IT_AUIPC: begin
                s32     = {bus.in_inst[31:12], 12'b0};
                dec.imm = XLEN'(s32);
            end
            IT_JAL: begin
                s32     = 32'($signed({bus.in_inst[31], bus.in_inst[19:12], bus.in_inst[20],
                                       bus.in_inst[30:21], 1'b0}));
                dec.imm = XLEN'(s32);
            end
            IT_REG:   dec.imm = '0;
            IT_CSR:   dec.imm = XLEN'(bus.in_inst[19:15]);
            IT_SHIFT: begin
                if (XLEN == 64) dec.imm = XLEN'(bus.in_inst[25:20]);
                else            dec.imm = XLEN'(bus.in_inst[24:20]);
            end
            default:  dec.ill = 1'b1;
        endcase
    end

    assign in_xfer  = bus.in_valid && in_ready_q;
    assign out_xfer = out_valid_q && bus.out_ready;

    // Skid entry only fills while the output register is stalled, so it can
    // never be valid with the output register empty; order stays FIFO.
    always_comb begin
        out_d        = out_q;
        out_valid_d  = out_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        if (flush) begin
            out_d        = '0;
            out_valid_d  = 1'b0;
            skid_d       = '0;
            skid_valid_d = 1'b0;
        end else if (!out_valid_q || out_xfer) begin
            if (skid_valid_q) begin
                out_d        = skid_q;
                out_valid_d  = 1'b1;
                skid_d       = '0;
                skid_valid_d = 1'b0;
            end else if (in_xfer) begin
                out_d       = dec;
                out_valid_d = 1'b1;
            end else begin
                out_d       = '0;
                out_valid_d = 1'b0;
            end
        end else if (in_xfer) begin
            skid_d       = dec;
            skid_valid_d = 1'b1;
        end
        in_ready_d = !skid_valid_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q        <= '0;
            out_valid_q  <= 1'b0;
            skid_q       <= '0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
        end else begin
            out_q        <= out_d;
            out_valid_q  <= out_valid_d;
            skid_q       <= skid_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= in_ready_d;
        end
    end

    assign bus.in_ready    = in_ready_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_imm     = out_q.imm;
    assign bus.out_tag     = out_q.tag;
    assign bus.out_illegal = out_q.ill;
endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: XLEN=32 and XLEN=64 instances share one stimulus and
// are checked every cycle against a queue model, plus directed literals.
module tb_imm_gen_pipe;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic flush = 1'b0;
    logic in_valid = 1'b0;
    logic [3:0] in_type = '0;
    logic [31:0] in_inst = '0;
    logic [4:0] in_tag = '0;
    logic out_ready = 1'b1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    imm_gen_pipe_if #(.XLEN(32), .TAG_W(5)) b32();
    imm_gen_pipe_if #(.XLEN(64), .TAG_W(5)) b64();

    assign b32.in_valid = in_valid;
    assign b32.in_type = in_type;
    assign b32.in_inst = in_inst;
    assign b32.in_tag = in_tag;
    assign b32.out_ready = out_ready;
    assign b64.in_valid = in_valid;
    assign b64.in_type = in_type;
    assign b64.in_inst = in_inst;
    assign b64.in_tag = in_tag;
    assign b64.out_ready = out_ready;

    imm_gen_pipe #(.XLEN(32), .TAG_W(5)) dut32 (.clk(clk), .rst(rst), .flush(flush), .bus(b32.slave));
    imm_gen_pipe #(.XLEN(64), .TAG_W(5)) dut64 (.clk(clk), .rst(rst), .flush(flush), .bus(b64.slave));

    typedef struct {
        logic [63:0] i32;
        logic [63:0] i64;
        logic [4:0]  tag;
        logic        ill;
    } exp_t;
    exp_t q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Immediate value as a signed integer built from instruction fields.
    function automatic logic [63:0] model_imm(input int xlen, input logic [3:0] t, input logic [31:0] w);
        longint s;
        longint v;
        s = $signed(w);
        v = 0;
        case (t)
            4'd0, 4'd1, 4'd7: v = s >>> 20;
            4'd2: v = ((s >>> 25) <<< 5) + longint'(w[11:7]);
            4'd6: v = ((s >>> 31) <<< 12) + longint'(w[7]) * 2048 + longint'(w[30:25]) * 32
                      + longint'(w[11:8]) * 2;
            4'd4, 4'd5: v = (s >>> 12) <<< 12;
            4'd8: v = ((s >>> 31) <<< 20) + longint'(w[19:12]) * 4096 + longint'(w[20]) * 2048
                      + longint'(w[30:21]) * 2;
            4'd9: v = longint'(w[19:15]);
            4'd10: v = (xlen == 64) ? longint'(w[25:20]) : longint'(w[24:20]);
            default: v = 0;
        endcase
        if (xlen == 32) return {32'b0, v[31:0]};
        return v;
    endfunction

    function automatic exp_t mk(input logic [3:0] t, input logic [31:0] w, input logic [4:0] tg);
        exp_t e;
        e.i32 = model_imm(32, t, w);
        e.i64 = model_imm(64, t, w);
        e.tag = tg;
        e.ill = (t >= 4'd11);
        return e;
    endfunction

    // Occupancy model: up to two held entries, acceptance whenever fewer than two.
    always @(posedge clk or posedge rst) begin : model_upd
        bit acc;
        if (rst) begin
            q.delete();
        end else if (flush) begin
            q.delete();
        end else begin
            acc = in_valid && (q.size() < 2);
            if (q.size() > 0 && out_ready) void'(q.pop_front());
            if (acc) q.push_back(mk(in_type, in_inst, in_tag));
        end
    end

    always @(negedge clk) begin : compare
        exp_t e;
        e.i32 = '0;
        e.i64 = '0;
        e.tag = '0;
        e.ill = 1'b0;
        if (q.size() > 0) e = q[0];
        chk("valid32", 64'(b32.out_valid), 64'(q.size() > 0));
        chk("valid64", 64'(b64.out_valid), 64'(q.size() > 0));
        chk("ready32", 64'(b32.in_ready), 64'(q.size() < 2));
        chk("ready64", 64'(b64.in_ready), 64'(q.size() < 2));
        chk("imm32", 64'(b32.out_imm), e.i32);
        chk("imm64", b64.out_imm, e.i64);
        chk("tag32", 64'(b32.out_tag), 64'(e.tag));
        chk("tag64", 64'(b64.out_tag), 64'(e.tag));
        chk("ill32", 64'(b32.out_illegal), 64'(e.ill));
        chk("ill64", 64'(b64.out_illegal), 64'(e.ill));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [3:0] t, input logic [31:0] w, input logic [4:0] tg);
        in_valid = 1'b1;
        in_type = t;
        in_inst = w;
        in_tag = tg;
    endtask

    logic [3:0]  st_t[7] = '{4'd4, 4'd8, 4'd6, 4'd2, 4'd0, 4'd3, 4'd1};
    logic [31:0] st_i[7] = '{32'h030391b7, 32'h038031ef, 32'h08418063, 32'h08320023,
                             32'h08020183, 32'h005201b3, 32'h07b20193};
    logic [63:0] st_e[7] = '{64'h03039000, 64'd12344, 64'd128, 64'd128, 64'd128, 64'd0, 64'd123};

    initial begin
        logic [4:0] seen[$];
        bit acc;
        bit ox;
        logic [4:0] otag;

        for (int i = 0; i < 7; i++) chk("model_vec", model_imm(32, st_t[i], st_i[i]), st_e[i]);
        chk("model_sext32", model_imm(32, 4'd1, 32'hfff00093), 64'hFFFFFFFF);
        chk("model_sext64", model_imm(64, 4'd1, 32'hfff00093), 64'hFFFFFFFFFFFFFFFF);
        chk("model_shamt32", model_imm(32, 4'd10, 32'h03f0d093), 64'd31);
        chk("model_shamt64", model_imm(64, 4'd10, 32'h03f0d093), 64'd63);

        #1 rst = 1'b1;
        #11;
        chk("rst_valid", 64'(b32.out_valid), 64'd0);
        chk("rst_ready", 64'(b32.in_ready), 64'd1);
        chk("rst_imm", b64.out_imm, 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            offer(st_t[i], st_i[i], 5'(i + 1));
            step();
            chk("stream_imm", 64'(b32.out_imm), st_e[i]);
        end
        in_valid = 1'b0;

        offer(4'd1, 32'hfff00093, 5'd1);
        step();
        chk("sext32", 64'(b32.out_imm), 64'hFFFFFFFF);
        chk("sext64", b64.out_imm, 64'hFFFFFFFFFFFFFFFF);
        offer(4'd10, 32'h03f0d093, 5'd2);
        step();
        chk("shamt32", 64'(b32.out_imm), 64'd31);
        chk("shamt64", b64.out_imm, 64'd63);
        in_valid = 1'b0;
        step();

        out_ready = 1'b0;
        offer(4'd1, 32'h00100093, 5'd1);
        step();
        offer(4'd1, 32'h00200093, 5'd2);
        step();
        offer(4'd1, 32'h00300093, 5'd3);
        step();
        chk("bp_ready_low", 64'(b32.in_ready), 64'd0);
        chk("bp_hold_tag", 64'(b32.out_tag), 64'd1);
        step();
        chk("bp_hold_imm", 64'(b32.out_imm), 64'd1);
        out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            acc = b32.in_ready && in_valid;
            ox = b32.out_valid && out_ready;
            otag = b32.out_tag;
            step();
            if (ox) seen.push_back(otag);
            if (acc) in_valid = 1'b0;
        end
        chk("bp_count", 64'(seen.size()), 64'd3);
        for (int k = 0; k < 3; k++) begin
            if (k < seen.size()) chk("bp_order", 64'(seen[k]), 64'(k + 1));
            else chk("bp_order", 64'd0, 64'(k + 1));
        end

        out_ready = 1'b0;
        offer(4'd1, 32'h00400093, 5'd4);
        step();
        offer(4'd1, 32'h00500093, 5'd5);
        step();
        chk("fl_full", 64'(b32.in_ready), 64'd0);
        flush = 1'b1;
        offer(4'd1, 32'h00700093, 5'd7);
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("fl_valid", 64'(b32.out_valid), 64'd0);
        chk("fl_ready", 64'(b32.in_ready), 64'd1);
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            chk("fl_gone", 64'(b32.out_valid), 64'd0);
        end

        out_ready = 1'b0;
        offer(4'd12, 32'hffffffff, 5'd9);
        step();
        in_valid = 1'b0;
        chk("ill_flag", 64'(b32.out_illegal), 64'd1);
        chk("ill_imm", b64.out_imm, 64'd0);
        chk("ill_valid", 64'(b32.out_valid), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst_valid32", 64'(b32.out_valid), 64'd0);
        chk("arst_valid64", 64'(b64.out_valid), 64'd0);
        chk("arst_ready", 64'(b32.in_ready), 64'd1);
        chk("arst_ill", 64'(b32.out_illegal), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        out_ready = 1'b1;
        offer(4'd1, 32'h07b20193, 5'd11);
        step();
        in_valid = 1'b0;
        chk("post_rst_valid", 64'(b32.out_valid), 64'd1);
        chk("post_rst_tag", 64'(b32.out_tag), 64'd11);
        chk("post_rst_imm", b64.out_imm, 64'd123);
        step();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
